// File: rtl/fp_round_pack.sv
// Rounds a normalized floating-point sum to nearest-even and packs it into {sign, exponent, fraction}.
// Carry shifts, the round step, one renormalization and the pack each take one clock; the result is held until accepted.
module fp_round_pack #(
    parameter int unsigned EXPBITS      = 8,
    parameter int unsigned MANTISSABITS = 23
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic                            InValid,
    output logic                            InReady,
    input  logic                            Sign,
    input  logic [EXPBITS-1:0]              Exp,
    input  logic [MANTISSABITS+1:0]         Mantissa,
    input  logic [2:0]                      GRS,
    output logic                            OutValid,
    input  logic                            OutReady,
    output logic [EXPBITS+MANTISSABITS:0]   Result,
    output logic                            Overflow
);

    localparam int unsigned MW    = MANTISSABITS + 2;
    localparam int unsigned EW    = EXPBITS + 1;
    localparam int unsigned CARRY = MANTISSABITS + 1;
    localparam int unsigned HIDE  = MANTISSABITS;

    localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXPBITS{1'b1}}};

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CHECK  = 3'd1;
    localparam logic [2:0] ROUND  = 3'd2;
    localparam logic [2:0] RENORM = 3'd3;
    localparam logic [2:0] PACK   = 3'd4;
    localparam logic [2:0] HOLD   = 3'd5;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic          sgn;
    logic [EW-1:0] exp_q;
    logic [MW-1:0] man;
    logic          g;
    logic          r;
    logic          s;
    logic          grs_zero;
    logic          round_up_c;
    logic [MW-1:0] man_rnd_c;

    // Round-to-nearest-even increment on the current mantissa
    always_comb begin
        round_up_c = g & (r | s | man[0]);
        man_rnd_c  = man + MW'(round_up_c);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (InValid) state_next = CHECK;
            CHECK:   if (!man[CARRY]) state_next = ROUND;
            ROUND:   state_next = man_rnd_c[CARRY] ? RENORM : PACK;
            RENORM:  state_next = PACK;
            PACK:    state_next = HOLD;
            HOLD:    if (OutReady) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            InReady  <= 1'b1;
            OutValid <= 1'b0;
        end else begin
            state    <= state_next;
            InReady  <= (state_next == IDLE);
            OutValid <= (state_next == HOLD);
        end
    end

    // Operand datapath; Result/Overflow change only in PACK
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sgn      <= 1'b0;
            exp_q    <= '0;
            man      <= '0;
            g        <= 1'b0;
            r        <= 1'b0;
            s        <= 1'b0;
            grs_zero <= 1'b0;
            Result   <= '0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        sgn      <= Sign;
                        exp_q    <= {1'b0, Exp};
                        man      <= Mantissa;
                        g        <= GRS[2];
                        r        <= GRS[1];
                        s        <= GRS[0];
                        grs_zero <= (GRS == 3'b000);
                    end
                end
                CHECK: begin
                    if (man[CARRY]) begin
                        man   <= man >> 1;
                        g     <= man[0];
                        r     <= g;
                        s     <= r | s;
                        exp_q <= exp_q + EW'(1);
                    end
                end
                ROUND: man <= man_rnd_c;
                RENORM: begin
                    man   <= man >> 1;
                    exp_q <= exp_q + EW'(1);
                end
                PACK: begin
                    if (exp_q >= EXP_MAX) begin
                        Result   <= {sgn, {EXPBITS{1'b1}}, {MANTISSABITS{1'b0}}};
                        Overflow <= 1'b1;
                    end else if (man == '0 && grs_zero) begin
                        Result   <= {sgn, {EXPBITS{1'b0}}, {MANTISSABITS{1'b0}}};
                        Overflow <= 1'b0;
                    end else if (!man[HIDE] && exp_q == '0) begin
                        // Denormal: fraction passes through with a zero exponent
                        Result   <= {sgn, {EXPBITS{1'b0}}, man[MANTISSABITS-1:0]};
                        Overflow <= 1'b0;
                    end else begin
                        Result   <= {sgn, exp_q[EXPBITS-1:0], man[MANTISSABITS-1:0]};
                        Overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Directed bench for fp_round_pack: rounding, carries, overflow, zero/denormal packing, backpressure and reset.
module tb_fp_round_pack;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic        Sign;
    logic [7:0]  Exp;
    logic [24:0] Mantissa;
    logic [2:0]  GRS;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] Result;
    logic        Overflow;

    int vectors   = 0;
    int miscomps  = 0;

    fp_round_pack #(.EXPBITS(8), .MANTISSABITS(23)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .Sign     (Sign),
        .Exp      (Exp),
        .Mantissa (Mantissa),
        .GRS      (GRS),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result),
        .Overflow (Overflow)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscomps++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Present one operand for a single accepting edge; returns at edge+1
    task automatic start_op(input logic sg, input logic [7:0] e, input logic [24:0] m, input logic [2:0] grs);
        check("in_ready_before_accept", 64'(InReady), 64'd1);
        Sign = sg; Exp = e; Mantissa = m; GRS = grs; InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!OutValid && lat < 20) begin
            @(posedge Clock); #1;
            lat++;
        end
    endtask

    task automatic release_out(input string tag, input logic [31:0] res);
        OutReady = 1'b1;
        @(posedge Clock); #1;
        OutReady = 1'b0;
        check({tag, "_released_valid"}, 64'(OutValid), 64'd0);
        check({tag, "_released_ready"}, 64'(InReady), 64'd1);
        check({tag, "_result_kept"}, 64'(Result), 64'(res));
    endtask

    task automatic run(input string tag, input logic sg, input logic [7:0] e, input logic [24:0] m,
                       input logic [2:0] grs, input logic [31:0] res, input logic ovf, input int lat_exp);
        int lat;
        start_op(sg, e, m, grs);
        wait_valid(lat);
        check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        check({tag, "_valid"}, 64'(OutValid), 64'd1);
        check({tag, "_result"}, 64'(Result), 64'(res));
        check({tag, "_overflow"}, 64'(Overflow), 64'(ovf));
        check({tag, "_in_ready_busy"}, 64'(InReady), 64'd0);
        release_out(tag, res);
    endtask

    initial begin
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        Sign = 1'b0; Exp = '0; Mantissa = '0; GRS = '0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        check("rst_out_valid", 64'(OutValid), 64'd0);
        check("rst_result", 64'(Result), 64'd0);
        check("rst_overflow", 64'(Overflow), 64'd0);
        check("rst_in_ready", 64'(InReady), 64'd1);

        run("one",        1'b0, 8'h7F, 25'h0800000, 3'b000, 32'h3F800000, 1'b0, 3);
        run("tie_odd",    1'b0, 8'h7F, 25'h0800001, 3'b100, 32'h3F800002, 1'b0, 3);
        run("tie_even",   1'b0, 8'h7F, 25'h0800000, 3'b100, 32'h3F800000, 1'b0, 3);
        run("sticky_up",  1'b0, 8'h7F, 25'h0800000, 3'b101, 32'h3F800001, 1'b0, 3);
        run("below_half", 1'b0, 8'h7F, 25'h0800001, 3'b011, 32'h3F800001, 1'b0, 3);
        run("pre_carry_ovf", 1'b1, 8'hFE, 25'h1FFFFFF, 3'b000, 32'hFF800000, 1'b1, 5);
        run("round_carry",   1'b0, 8'h7F, 25'h0FFFFFF, 3'b110, 32'h40000000, 1'b0, 4);
        run("exp_ovf",    1'b0, 8'hFF, 25'h0800000, 3'b000, 32'h7F800000, 1'b1, 3);
        run("neg_zero",   1'b1, 8'h10, 25'h0000000, 3'b000, 32'h80000000, 1'b0, 3);
        run("denormal",   1'b0, 8'h00, 25'h0012345, 3'b000, 32'h00012345, 1'b0, 3);
        // Pre-round carry without overflow: 1.5*2 style shift drops a 1 into G, tie to even
        run("carry_shift", 1'b0, 8'h80, 25'h1000001, 3'b000, 32'h40800000, 1'b0, 4);

        begin : backpressure
            int lat;
            start_op(1'b0, 8'h7F, 25'h0800000, 3'b000);
            wait_valid(lat);
            check("bp_latency", 64'(lat), 64'd3);
            for (int i = 0; i < 10; i++) begin
                @(posedge Clock); #1;
                check("bp_valid_held", 64'(OutValid), 64'd1);
                check("bp_result_held", 64'(Result), 64'h3F800000);
                check("bp_in_ready_low", 64'(InReady), 64'd0);
            end
            release_out("bp", 32'h3F800000);
        end

        begin : reset_mid_op
            start_op(1'b0, 8'h7F, 25'h0800001, 3'b100);
            @(posedge Clock); #1;
            Reset = 1'b1;
            @(posedge Clock); #1;
            Reset = 1'b0;
            check("midrst_valid", 64'(OutValid), 64'd0);
            check("midrst_result", 64'(Result), 64'd0);
            check("midrst_in_ready", 64'(InReady), 64'd1);
            repeat (6) @(posedge Clock);
            #1;
            check("midrst_discarded", 64'(OutValid), 64'd0);
        end

        begin : reset_ignores_valid
            Sign = 1'b0; Exp = 8'h7F; Mantissa = 25'h0800000; GRS = 3'b000;
            InValid = 1'b1; Reset = 1'b1;
            @(posedge Clock); #1;
            InValid = 1'b0; Reset = 1'b0;
            check("rstvalid_in_ready", 64'(InReady), 64'd1);
            repeat (6) @(posedge Clock);
            #1;
            check("rstvalid_no_output", 64'(OutValid), 64'd0);
            check("rstvalid_in_ready_idle", 64'(InReady), 64'd1);
        end

        run("after_reset", 1'b1, 8'h81, 25'h0C00000, 3'b000, 32'hC0C00000, 1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomps);
        $finish;
    end

endmodule
